pixel_write_master: RTL
=======================

# pixel_write_master

Memory-side responder for the pixel-plotting interface driven by the line-drawing circuits. It accepts one pixel request at a time (`Draw`, `Pixel_Address`, `Color`) and performs a single 16-bit Avalon-MM write to the SRAM frame buffer. It returns a one-cycle `Write_Finish` pulse per request, and drops, but still acknowledges, requests outside the frame buffer. It sits between the drawing FSMs and the system interconnect's SRAM slave.

## Interface
- `FB_BASE`, default 32'h08000000, first byte address of the frame buffer.
- `FB_BYTES`, default 32'h00040000, frame buffer size in bytes; valid addresses are FB_BASE .. FB_BASE+FB_BYTES-1.
- `clk`  in  1  system clock.
- `reset`  in  1  **one clock; reset is asynchronous and active-high**.
- `Draw`  in  1  level request; a pixel is pending while high.
- `Pixel_Address`  in  32  byte address of the pixel; must be even.
- `Color`  in  16  RGB565 pixel value.
- `Write_Finish`  out  1  one-cycle acknowledge per accepted request.
- `Busy`  out  1  high in any state other than IDLE.
- `master_address`  out  32  Avalon write address.
- `master_write`  out  1  Avalon write strobe.
- `master_writedata`  out  16  Avalon write data.
- `master_byteenable`  out  2  always 2'b11 while `master_write` is high, 2'b00 otherwise.
- `master_waitrequest`  in  1  Avalon stall.
- `count_clear`  in  1  synchronous clear of both counters.
- `pixel_count`  out  16  completed bus writes, saturating.
- `drop_count`  out  16  dropped requests, saturating.

## Operation
- The FSM has three states: IDLE, WRITE and ACK. Reset state is IDLE.
- **IDLE:**
  - If `Draw`=1 at the clock edge, capture `Pixel_Address` and `Color` into internal registers.
  - If the address is valid (within range and bit0=0), go to WRITE.
  - Otherwise, go directly to ACK and increment `drop_count`.
- **WRITE:**
  - `master_write`=1, `master_address`=captured address, `master_writedata`=captured color.
  - Outputs hold stable while `master_waitrequest`=1.
  - At the first edge with `master_waitrequest`=0, go to ACK and increment `pixel_count`.
- **ACK:** `Write_Finish`=1 for exactly this cycle, then return to IDLE unconditionally.
- **Recovery cycle:** the requester updates `Pixel_Address` in response to `Write_Finish`. IDLE is the recovery cycle, so a held `Draw` is re-sampled with the new address and a stale address is never written twice.
- **Range check:** `Pixel_Address - FB_BASE` is computed as a 33-bit unsigned value. Any borrow, or a result ≥ FB_BYTES, is out of range.
- **Draw deasserted mid-transfer:** if `Draw` falls during WRITE, the transfer still completes and `Write_Finish` still pulses. There is no abort on the bus.
- **Counters:**
  - `pixel_count` and `drop_count` stop at 16'hFFFF.
  - `count_clear` has priority over an increment in the same cycle.
- **Inputs ignored:** `Color` and `Pixel_Address` are ignored outside the IDLE capture edge.

## Timing
- **Reset values (immediately on `reset` assertion, asynchronous):**
  - State is IDLE.
  - `master_write`, `Write_Finish` and `Busy` are 0.
  - `master_address` and `master_writedata` are 0.
  - `master_byteenable` is 2'b00.
  - Both counters are 0.
- **Reset mid-transfer:** `master_write` drops in the same cycle and the pending write is abandoned, with no `Write_Finish`.
- **Zero-wait latency:**
  - `Draw` sampled at edge N.
  - `master_write` high during cycle N+1.
  - `Write_Finish` high during cycle N+2.
  - IDLE in cycle N+3; the next `Draw` is sampled at edge N+3.
- **Throughput:** one pixel per 3 cycles, plus k cycles when `master_waitrequest` is high for k edges.
- **Dropped request:** `Draw` sampled at edge N gives `Write_Finish` during cycle N+1, next sample at edge N+2.
- **Busy:** high from the cycle after capture until the cycle the FSM re-enters IDLE.
- **Outputs are registered:** all outputs are driven from registered state; there is no combinational path from `Draw` or `master_waitrequest` to any output.

## Test plan
- **Single zero-wait write:**
  - Stimulus: `Draw`=1, address 0x08000100, color 0xF800, `master_waitrequest`=0.
  - Response: one write to 0x08000100 with data 0xF800 and byteenable 11, `Write_Finish` 2 cycles after capture, `pixel_count`=1.
- **Wait states:**
  - Stimulus: `master_waitrequest` high for 4 edges.
  - Response: address and data held stable for 5 cycles, `Write_Finish` 6 cycles after capture, exactly one write.
- **Held Draw, address sequence:**
  - Stimulus: `Draw` held high; address advanced by 2 on each `Write_Finish`, over 10 pixels starting at 0x08000000.
  - Response: 10 writes at 0x08000000..0x08000012, no duplicates, 30 cycles total.
- **Drops:**
  - Stimulus: addresses 0x07FFFFFE, 0x08040000 and 0x08000001.
  - Response: no `master_write`, three `Write_Finish` pulses 2 cycles apart, `drop_count`=3, `pixel_count` unchanged.
- **Reset mid-transfer:**
  - Stimulus: assert `reset` in WRITE while `master_waitrequest`=1.
  - Response: `master_write`=0 in the same cycle, no `Write_Finish`, counters 0; the next request after release proceeds normally.
- **Counter saturation and clear:**
  - Stimulus: preload `pixel_count` to 0xFFFF via 65535 writes, then one more write; then `count_clear` coincident with a completing write.
  - Response: the count stays 0xFFFF after the extra write, then reads 0 after the clear.

Source files
------------

// File: rtl/pixel_write_master_if.sv
// Pixel request / Avalon-MM write bundle between the drawing FSMs, the responder and the SRAM slave.
// Pure wiring, no latency.
// Backpressure arrives on master_waitrequest; the requester waits for Write_Finish.
interface pixel_write_master_if;
    // Request side from the line-drawing circuits
    logic        Draw;
    logic [31:0] Pixel_Address;
    logic [15:0] Color;
    logic        Write_Finish;
    logic        Busy;
    // Avalon-MM write master towards the SRAM slave
    logic [31:0] master_address;
    logic        master_write;
    logic [15:0] master_writedata;
    logic [1:0]  master_byteenable;
    logic        master_waitrequest;
    // Statistics
    logic        count_clear;
    logic [15:0] pixel_count;
    logic [15:0] drop_count;

    // Responder view (pixel_write_master)
    modport slave (
        input  Draw, Pixel_Address, Color, master_waitrequest, count_clear,
        output Write_Finish, Busy, master_address, master_write,
               master_writedata, master_byteenable, pixel_count, drop_count
    );

    // Requester / bus-model view
    modport master (
        output Draw, Pixel_Address, Color, master_waitrequest, count_clear,
        input  Write_Finish, Busy, master_address, master_write,
               master_writedata, master_byteenable, pixel_count, drop_count
    );
endinterface

// File: rtl/pixel_write_master.sv
// Turns one Draw request into one 16-bit Avalon write to the frame buffer, acking with Write_Finish.
// Latency: Write_Finish 2 cycles after capture (+1 per waitrequest edge), 1 cycle for dropped requests.
// Backpressure: master_waitrequest holds the write; Draw is only sampled in IDLE.
module pixel_write_master #(
    parameter logic [31:0] FB_BASE  = 32'h0800_0000,
    parameter logic [31:0] FB_BYTES = 32'h0004_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_write_master_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [15:0] r_color;
    logic [15:0] r_pixel_count;
    logic [15:0] r_drop_count;

    logic        w_capture;
    logic        w_inc_pix;
    logic        w_inc_drop;
    logic [32:0] w_offset;
    logic        w_addr_ok;

    // A borrow (bit 32) means the address lies below the frame buffer.
    assign w_offset  = {1'b0, bus.Pixel_Address} - {1'b0, FB_BASE};
    assign w_addr_ok = !w_offset[32] && (w_offset[31:0] < FB_BYTES) && !bus.Pixel_Address[0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-edge event decode
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_inc_pix  = 1'b0;
        w_inc_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Draw) begin
                    w_capture = 1'b1;
                    if (w_addr_ok) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next     = S_ACK;
                        w_inc_drop = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (!bus.master_waitrequest) begin
                    w_next    = S_ACK;
                    w_inc_pix = 1'b1;
                end
            end
            // IDLE after ACK is the recovery cycle in which the requester advances its address.
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture address and colour only on the IDLE sampling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_color <= '0;
        end else if (w_capture) begin
            r_addr  <= bus.Pixel_Address;
            r_color <= bus.Color;
        end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixel_count <= '0;
            r_drop_count  <= '0;
        end else if (bus.count_clear) begin
            r_pixel_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_inc_pix && (r_pixel_count != 16'hFFFF)) begin
                r_pixel_count <= r_pixel_count + 16'd1;
            end
            if (w_inc_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // All outputs decode registered state only, so reset drops the write strobe immediately.
    assign bus.master_write      = (r_state == S_WRITE);
    assign bus.master_address    = r_addr;
    assign bus.master_writedata  = r_color;
    assign bus.master_byteenable = (r_state == S_WRITE) ? 2'b11 : 2'b00;
    assign bus.Write_Finish      = (r_state == S_ACK);
    assign bus.Busy              = (r_state != S_IDLE);
    assign bus.pixel_count       = r_pixel_count;
    assign bus.drop_count        = r_drop_count;

endmodule
